memory_address_unit: RTL and testbench
======================================

MEMORY_ADDRESS_UNIT -- requirements
Module: memory_address_unit

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the address bus width.
REQ-002 Parameter LEN_W, default 4, SHALL set the burst-length field width; beats per burst = burst_len+1.
REQ-003 Parameter STRIDE, default 1, SHALL set the address increment per accepted beat.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  input  1  SHALL request a new burst; sampled only in IDLE.
REQ-007 start_addr  input  ADDR_W  SHALL give the first beat address, latched with start.
REQ-008 burst_len  input  LEN_W  SHALL give beats minus one, latched with start.
REQ-009 wrap_en  input  1  SHALL select wrapping burst mode, latched with start.
REQ-010 wrap_mask  input  ADDR_W  SHALL give the wrap window bits (low-order ones), latched with start.
REQ-011 abort  input  1  SHALL terminate an active burst.
REQ-012 mem_addr  output  ADDR_W  SHALL be the registered address presented to memory.
REQ-013 mem_valid  output  1  SHALL indicate that mem_addr is a valid beat request.
REQ-014 mem_ready  input  1  SHALL indicate that memory accepts the current beat.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.
REQ-016 done  output  1  SHALL pulse high for one cycle after the final beat is accepted.
REQ-017 beat_cnt  output  LEN_W  SHALL give the number of beats accepted so far in the current burst.

Function
REQ-018 States SHALL be IDLE, BURST and DONE.
REQ-019 IDLE + start=1: latch all inputs, load mem_addr=start_addr and beat_cnt=0, set mem_valid=1, go to BURST (first request visible one cycle after start).
REQ-020 A beat SHALL be accepted on any edge with mem_valid=1 and mem_ready=1.
REQ-021 mem_addr and mem_valid SHALL hold stable while mem_valid=1 and mem_ready=0.
REQ-022 Accepted beat, not the last one: mem_addr advances; beat_cnt increments; mem_valid stays 1, so there are no bubbles at mem_ready=1.
REQ-023 Linear advance: mem_addr = (mem_addr+STRIDE) mod 2^ADDR_W; wrap-around at the top of the address space is silent.
REQ-024 Wrap advance: mem_addr = (mem_addr & ~wrap_mask) | ((mem_addr+STRIDE) & wrap_mask); the upper bits never change.
REQ-025 Accepting the last beat (beat_cnt==latched burst_len): mem_valid=0, go to DONE; mem_addr keeps the last beat address.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 start in BURST or DONE SHALL be ignored, with no latch and no queueing.
REQ-028 abort in BURST SHALL force IDLE on the next edge with mem_valid=0 and no done pulse.
REQ-029 abort coinciding with an accepted beat: the beat counts as transferred, but abort still wins (IDLE, no done).
REQ-030 abort in IDLE or DONE SHALL have no effect; the done pulse is still delivered.
REQ-031 burst_len=0 SHALL give a single-beat burst: one request, then done.
REQ-032 In IDLE, mem_addr and beat_cnt SHALL hold their last values.

Reset
REQ-033 reset=0 SHALL immediately set state=IDLE, mem_addr=0, mem_valid=0, busy=0, done=0 and beat_cnt=0, and clear all latched fields.
REQ-034 Reset asserted mid-burst SHALL abandon the burst, with no done pulse after release.
REQ-035 The first start honoured SHALL be the one sampled on the first edge after reset deasserts.

Structure
REQ-036 Package mau_pkg SHALL hold the state enum (IDLE, BURST, DONE) and the default values of ADDR_W, LEN_W and STRIDE.
REQ-037 Sub-module mau_addr_next (combinational; inputs addr, wrap_en, wrap_mask; output next address) SHALL implement REQ-023 and REQ-024.
REQ-038 All outputs SHALL be driven directly from registers.

Verification
REQ-039 Linear burst: start_addr=0x1000, burst_len=3, mem_ready=1 -> mem_addr 0x1000, 0x1001, 0x1002, 0x1003 on consecutive cycles, done one cycle after the 4th beat.
REQ-040 Wrap burst: start_addr=0x200E, wrap_mask=0x000F, burst_len=3 -> mem_addr 0x200E, 0x200F, 0x2000, 0x2001.
REQ-041 Backpressure: mem_ready low for 3 cycles on beat 2 -> mem_addr holds the beat-2 address and mem_valid stays 1; the burst then completes with beat_cnt=3.
REQ-042 Abort: abort on beat 2 together with mem_ready=1 -> IDLE next cycle, mem_valid=0, beat_cnt=2, no done.
REQ-043 Top-of-space wrap: start_addr=0xFFFF, wrap_en=0, burst_len=1 -> mem_addr 0xFFFF then 0x0000.
REQ-044 Reset and start: reset low mid-burst -> outputs zero at once; a start issued while busy is ignored; a single beat (burst_len=0) gives one request and one done.

Source files
------------

// File: rtl/mau_pkg.sv
// -----------------------------------------------------------------------------
// mau_pkg
// Shared definitions for the memory address unit:
//   - state_e      : burst controller states (IDLE, BURST, DONE)
//   - MAU_ADDR_W   : default address bus width
//   - MAU_LEN_W    : default burst-length field width (beats = burst_len + 1)
//   - MAU_STRIDE   : default address increment per accepted beat
// -----------------------------------------------------------------------------
package mau_pkg;

   localparam int MAU_ADDR_W = 16;
   localparam int MAU_LEN_W  = 4;
   localparam int MAU_STRIDE = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage : mau_pkg

// File: rtl/mau_if.sv
// -----------------------------------------------------------------------------
// mau_if
// Memory request channel between the address unit and the memory.
//   mem_addr  : beat address (driven by master)
//   mem_valid : mem_addr carries a valid beat request (driven by master)
//   mem_ready : memory accepts the current beat (driven by slave)
// A beat transfers on a rising edge where mem_valid and mem_ready are both 1.
// -----------------------------------------------------------------------------
interface mau_if #(
   parameter int ADDR_W = 16
) ();

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_valid;
   logic              mem_ready;

   modport master (
      output mem_addr,
      output mem_valid,
      input  mem_ready
   );

   modport slave (
      input  mem_addr,
      input  mem_valid,
      output mem_ready
   );

endinterface : mau_if

// File: rtl/mau_addr_next.sv
// -----------------------------------------------------------------------------
// mau_addr_next
// Combinational next-beat address generator.
//   addr_i      : current beat address
//   wrap_en_i   : 1 = wrapping burst, 0 = linear burst
//   wrap_mask_i : low-order ones selecting the wrap window
//   addr_o      : address of the following beat
// Linear mode adds STRIDE modulo 2^ADDR_W. Wrap mode adds STRIDE only inside
// the window selected by wrap_mask_i; bits outside the window never change.
// -----------------------------------------------------------------------------
module mau_addr_next
   import mau_pkg::*;
#(
   parameter int ADDR_W = MAU_ADDR_W,
   parameter int STRIDE = MAU_STRIDE
) (
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              wrap_en_i,
   input  logic [ADDR_W-1:0] wrap_mask_i,
   output logic [ADDR_W-1:0] addr_o
);

   logic [ADDR_W-1:0] addr_inc;

   // Carry out of the top bit is dropped, giving silent wrap at the top of
   // the address space.
   assign addr_inc = addr_i + ADDR_W'(STRIDE);

   always_comb begin
      if (wrap_en_i) begin
         addr_o = (addr_i & ~wrap_mask_i) | (addr_inc & wrap_mask_i);
      end else begin
         addr_o = addr_inc;
      end
   end

endmodule : mau_addr_next

// File: rtl/memory_address_unit.sv
// -----------------------------------------------------------------------------
// memory_address_unit
// Burst address generator. A start in IDLE latches the burst description and
// issues burst_len+1 beat requests on the mem channel, advancing the address
// (linear or wrapping) after every accepted beat, then pulses done.
//
// Ports:
//   clk        : single clock, rising edge
//   reset      : asynchronous active-low reset
//   start      : request a new burst (sampled only in IDLE)
//   start_addr : first beat address        (latched with start)
//   burst_len  : beats minus one            (latched with start)
//   wrap_en    : wrapping burst select      (latched with start)
//   wrap_mask  : wrap window, low-order 1s  (latched with start)
//   abort      : terminate an active burst (no done pulse)
//   mem        : request channel (mem_addr/mem_valid out, mem_ready in)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse after the final beat is accepted
//   beat_cnt   : beats accepted so far in the current burst; it holds at
//                burst_len once the final beat is accepted
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module memory_address_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W = MAU_ADDR_W,
   parameter int LEN_W  = MAU_LEN_W,
   parameter int STRIDE = MAU_STRIDE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              wrap_en,
   input  logic [ADDR_W-1:0] wrap_mask,
   input  logic              abort,
   mau_if.master             mem,
   output logic              busy,
   output logic              done,
   output logic [LEN_W-1:0]  beat_cnt
);

   // ---------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------
   state_e            state_q,     state_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic              valid_q,     valid_d;
   logic [LEN_W-1:0]  cnt_q,       cnt_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;

   // Burst description captured at start
   logic [LEN_W-1:0]  len_q,       len_d;
   logic              wrap_en_q,   wrap_en_d;
   logic [ADDR_W-1:0] wrap_mask_q, wrap_mask_d;

   logic [ADDR_W-1:0] addr_next;
   logic              beat_accept;
   logic              last_beat;

   mau_addr_next #(
      .ADDR_W (ADDR_W),
      .STRIDE (STRIDE)
   ) u_addr_next (
      .addr_i      (addr_q),
      .wrap_en_i   (wrap_en_q),
      .wrap_mask_i (wrap_mask_q),
      .addr_o      (addr_next)
   );

   assign beat_accept = valid_q & mem.mem_ready;
   // cnt_q indexes the beat currently on the bus, so the last beat is the
   // one whose index equals the latched length.
   assign last_beat   = (cnt_q == len_q);

   // ---------------------------------------------------------------------
   // Next-state and output logic
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a hold/default value before the case so
      // no path leaves one unassigned, which would infer a latch.
      state_d     = state_q;
      addr_d      = addr_q;
      valid_d     = valid_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      wrap_en_d   = wrap_en_q;
      wrap_mask_d = wrap_mask_q;

      unique case (state_q)
         IDLE: begin
            // abort has no effect here; mem_addr and beat_cnt hold.
            if (start) begin
               len_d       = burst_len;
               wrap_en_d   = wrap_en;
               wrap_mask_d = wrap_mask;
               addr_d      = start_addr;
               cnt_d       = '0;
               valid_d     = 1'b1;
               state_d     = BURST;
            end
         end

         BURST: begin
            if (beat_accept) begin
               if (last_beat) begin
                  // Address keeps the last beat; counter stays at burst_len.
                  valid_d = 1'b0;
                  state_d = DONE;
               end else begin
                  // valid stays high, so back-to-back beats have no bubble.
                  addr_d = addr_next;
                  cnt_d  = cnt_q + LEN_W'(1);
               end
            end
            // An accepted beat above still counts, but abort overrides the
            // state change and suppresses the done pulse.
            if (abort) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end

         DONE: begin
            // One-cycle state; start and abort are ignored.
            state_d = IDLE;
         end

         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // busy and done are registered copies of the decoded next state so the
   // outputs need no logic after the flops.
   assign busy_d = (state_d != IDLE);
   assign done_d = (state_d == DONE);

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   // NOTE: non-blocking assignments keep every flop sampling the pre-edge
   // values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         valid_q     <= 1'b0;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         len_q       <= '0;
         wrap_en_q   <= 1'b0;
         wrap_mask_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         valid_q     <= valid_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         len_q       <= len_d;
         wrap_en_q   <= wrap_en_d;
         wrap_mask_q <= wrap_mask_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign mem.mem_addr  = addr_q;
   assign mem.mem_valid = valid_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign beat_cnt      = cnt_q;

endmodule : memory_address_unit

// File: tb/tb_memory_address_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_address_unit
// Scoreboard bench: expected beats (address, beat count) are queued when a
// burst is started and compared by a monitor whenever a beat is accepted.
// Directed checks cover reset, done timing, backpressure, abort and reset.
// -----------------------------------------------------------------------------
module tb_memory_address_unit;

   localparam int ADDR_W = 16;
   localparam int LEN_W  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [LEN_W-1:0]  burst_len;
   logic              wrap_en;
   logic [ADDR_W-1:0] wrap_mask;
   logic              abort;
   logic              busy;
   logic              done;
   logic [LEN_W-1:0]  beat_cnt;

   mau_if #(.ADDR_W(ADDR_W)) mem ();

   memory_address_unit #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .STRIDE (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .start_addr (start_addr),
      .burst_len  (burst_len),
      .wrap_en    (wrap_en),
      .wrap_mask  (wrap_mask),
      .abort      (abort),
      .mem        (mem),
      .busy       (busy),
      .done       (done),
      .beat_cnt   (beat_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [LEN_W-1:0]  cnt;
   } beat_t;

   beat_t sb[$];
   int    n_checks   = 0;
   int    n_errors   = 0;
   int    done_seen  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_beat(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] c);
      beat_t b;
      b.addr = a;
      b.cnt  = c;
      sb.push_back(b);
   endtask

   // Drive one start pulse; returns just after the edge that samples it.
   task automatic do_start(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                           input logic we, input logic [ADDR_W-1:0] m);
      @(posedge clk);
      #1;
      start      = 1'b1;
      start_addr = a;
      burst_len  = len;
      wrap_en    = we;
      wrap_mask  = m;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("idle_timeout", {31'd0, busy}, 32'd0);
      @(negedge clk);
   endtask

   // Monitor: every accepted beat is compared against the scoreboard head.
   always @(negedge clk) begin
      if (reset) begin
         if (done) done_seen++;
         if (mem.mem_valid && mem.mem_ready) begin
            if (sb.size() == 0) begin
               check("beat_unexpected", 32'(sb.size()), 32'd1);
            end else begin
               beat_t e;
               e = sb.pop_front();
               check("beat_addr", 32'(mem.mem_addr), 32'(e.addr));
               check("beat_cnt", 32'(beat_cnt), 32'(e.cnt));
            end
         end
      end
   end

   initial begin
      int exp_done;
      reset         = 1'b0;
      start         = 1'b0;
      start_addr    = '0;
      burst_len     = '0;
      wrap_en       = 1'b0;
      wrap_mask     = '0;
      abort         = 1'b0;
      mem.mem_ready = 1'b0;
      exp_done      = 0;

      // Reset state
      #12;
      check("rst_addr",  32'(mem.mem_addr), 32'd0);
      check("rst_valid", {31'd0, mem.mem_valid}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      check("rst_cnt",   32'(beat_cnt), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Linear burst with exact done timing
      mem.mem_ready = 1'b1;
      push_beat(16'h1000, 4'd0);
      push_beat(16'h1001, 4'd1);
      push_beat(16'h1002, 4'd2);
      push_beat(16'h1003, 4'd3);
      do_start(16'h1000, 4'd3, 1'b0, 16'h0000);
      repeat (4) @(negedge clk);
      @(negedge clk);
      check("lin_done",  {31'd0, done}, 32'd1);
      check("lin_valid", {31'd0, mem.mem_valid}, 32'd0);
      check("lin_cnt",   32'(beat_cnt), 32'd3);
      check("lin_addr",  32'(mem.mem_addr), 32'h1003);
      @(negedge clk);
      check("lin_done_clr", {31'd0, done}, 32'd0);
      check("lin_busy_clr", {31'd0, busy}, 32'd0);
      exp_done++;
      check("lin_done_cnt", 32'(done_seen), 32'(exp_done));

      // Wrapping burst
      push_beat(16'h200E, 4'd0);
      push_beat(16'h200F, 4'd1);
      push_beat(16'h2000, 4'd2);
      push_beat(16'h2001, 4'd3);
      do_start(16'h200E, 4'd3, 1'b1, 16'h000F);
      wait_idle();
      exp_done++;
      check("wrap_done_cnt", 32'(done_seen), 32'(exp_done));

      // Backpressure on beat 2
      push_beat(16'h0100, 4'd0);
      push_beat(16'h0101, 4'd1);
      push_beat(16'h0102, 4'd2);
      push_beat(16'h0103, 4'd3);
      do_start(16'h0100, 4'd3, 1'b0, 16'h0000);
      @(posedge clk);
      #1 mem.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_valid", {31'd0, mem.mem_valid}, 32'd1);
         check("bp_addr",  32'(mem.mem_addr), 32'h0101);
         @(posedge clk);
      end
      #1 mem.mem_ready = 1'b1;
      wait_idle();
      check("bp_cnt", 32'(beat_cnt), 32'd3);
      exp_done++;
      check("bp_done_cnt", 32'(done_seen), 32'(exp_done));

      // Abort together with acceptance of beat 2
      push_beat(16'h3000, 4'd0);
      push_beat(16'h3001, 4'd1);
      do_start(16'h3000, 4'd5, 1'b0, 16'h0000);
      @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check("abort_busy",  {31'd0, busy}, 32'd0);
      check("abort_valid", {31'd0, mem.mem_valid}, 32'd0);
      check("abort_cnt",   32'(beat_cnt), 32'd2);
      check("abort_done",  {31'd0, done}, 32'd0);
      repeat (3) @(negedge clk);
      check("abort_done_cnt", 32'(done_seen), 32'(exp_done));

      // Top-of-space linear wrap
      push_beat(16'hFFFF, 4'd0);
      push_beat(16'h0000, 4'd1);
      do_start(16'hFFFF, 4'd1, 1'b0, 16'h0000);
      wait_idle();
      exp_done++;
      check("top_done_cnt", 32'(done_seen), 32'(exp_done));

      // Start while busy is ignored, then reset mid-burst
      mem.mem_ready = 1'b0;
      do_start(16'h4000, 4'd7, 1'b0, 16'h0000);
      @(negedge clk);
      check("stall_addr", 32'(mem.mem_addr), 32'h4000);
      do_start(16'h5000, 4'd0, 1'b0, 16'h0000);
      @(negedge clk);
      check("ign_addr",  32'(mem.mem_addr), 32'h4000);
      check("ign_busy",  {31'd0, busy}, 32'd1);
      check("ign_valid", {31'd0, mem.mem_valid}, 32'd1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_addr",  32'(mem.mem_addr), 32'd0);
      check("mid_rst_valid", {31'd0, mem.mem_valid}, 32'd0);
      check("mid_rst_busy",  {31'd0, busy}, 32'd0);
      check("mid_rst_cnt",   32'(beat_cnt), 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_busy", {31'd0, busy}, 32'd0);
         check("post_rst_done", {31'd0, done}, 32'd0);
      end
      check("post_rst_done_cnt", 32'(done_seen), 32'(exp_done));

      // Single-beat burst
      mem.mem_ready = 1'b1;
      push_beat(16'h0042, 4'd0);
      do_start(16'h0042, 4'd0, 1'b0, 16'h0000);
      @(negedge clk);
      @(negedge clk);
      check("single_done",  {31'd0, done}, 32'd1);
      check("single_valid", {31'd0, mem.mem_valid}, 32'd0);
      @(negedge clk);
      check("single_idle",  {31'd0, busy}, 32'd0);
      exp_done++;
      check("single_done_cnt", 32'(done_seen), 32'(exp_done));

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_memory_address_unit
